ft245_cmd_parser: RTL

//   Downstream consumer of the FT245 read-side FIFO (PC -> FPGA byte stream).

---
 rtl/ft245_cmd_parser.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/ft245_cmd_parser.sv
// Pulls bytes from the FT245 read FIFO, frames them as sync/addr/data/xor-checksum
// commands and hands each good command to the register logic over valid/ready.
//   state  | meaning
//   S_HUNT | discarding bytes until the sync marker
//   S_ADDR | waiting for the address byte
//   S_DATA | collecting payload bytes, first byte ends up in the MSBs
//   S_CHK  | waiting for the checksum byte
//   S_OUT  | command presented, intake paused until accepted
module ft245_cmd_parser #(
    parameter int          DATA_BYTES = 4,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
    parameter int          TIMEOUT    = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    rden,
    input  logic [7:0]              rddata,
    input  logic                    rdfifo_empty,
    output logic                    cmd_valid,
    input  logic                    cmd_ready,
    output logic [7:0]              cmd_addr,
    output logic [8*DATA_BYTES-1:0] cmd_data,
    output logic                    err_checksum,
    output logic                    err_timeout,
    output logic [15:0]             frame_cnt
);
    localparam int DW = 8 * DATA_BYTES;
    localparam int IW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BYTES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_HUNT, S_ADDR, S_DATA, S_CHK, S_OUT} state_t;

    state_t          state_q, state_d;
    logic            rd_pend_q, rd_pend_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [7:0]      chk_q, chk_d;
    logic [7:0]      addr_sh_q, addr_sh_d;
    logic [DW-1:0]   data_sh_q, data_sh_d;
    logic [7:0]      cmd_addr_q, cmd_addr_d;
    logic [DW-1:0]   cmd_data_q, cmd_data_d;
    logic            err_chk_q, err_chk_d;
    logic            err_tmo_q, err_tmo_d;
    logic [15:0]     frame_cnt_q, frame_cnt_d;
    logic            byte_v;

    // rden is gated by rst so every output reads 0 while reset is held
    assign rden   = !rst && !rdfifo_empty && !rd_pend_q && (state_q != S_OUT);
    assign byte_v = rd_pend_q;

    always_comb begin
        state_d     = state_q;
        rd_pend_d   = rden;
        tmo_d       = '0;
        idx_d       = idx_q;
        chk_d       = chk_q;
        addr_sh_d   = addr_sh_q;
        data_sh_d   = data_sh_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_data_d  = cmd_data_q;
        err_chk_d   = 1'b0;
        err_tmo_d   = 1'b0;
        frame_cnt_d = frame_cnt_q;

        // A byte arriving on the terminal count wins over the timeout
        if (state_q inside {S_ADDR, S_DATA, S_CHK} && !byte_v) begin
            if (tmo_q == TMO_LAST) begin
                err_tmo_d = 1'b1;
                state_d   = S_HUNT;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end

        case (state_q)
            S_HUNT: begin
                if (byte_v && rddata == SYNC_BYTE) state_d = S_ADDR;
            end
            S_ADDR: begin
                if (byte_v) begin
                    addr_sh_d = rddata;
                    chk_d     = rddata;
                    idx_d     = '0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (byte_v) begin
                    data_sh_d = (data_sh_q << 8) | DW'(rddata);
                    chk_d     = chk_q ^ rddata;
                    idx_d     = idx_q + 1'b1;
                    if (idx_q == IDX_LAST) state_d = S_CHK;
                end
            end
            S_CHK: begin
                if (byte_v) begin
                    if (rddata == chk_q) begin
                        cmd_addr_d = addr_sh_q;
                        cmd_data_d = data_sh_q;
                        state_d    = S_OUT;
                    end else begin
                        err_chk_d = 1'b1;
                        state_d   = S_HUNT;
                    end
                end
            end
            S_OUT: begin
                if (cmd_ready) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = S_HUNT;
                end
            end
            default: state_d = S_HUNT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_HUNT;
            rd_pend_q   <= 1'b0;
            tmo_q       <= '0;
            idx_q       <= '0;
            chk_q       <= '0;
            addr_sh_q   <= '0;
            data_sh_q   <= '0;
            cmd_addr_q  <= '0;
            cmd_data_q  <= '0;
            err_chk_q   <= 1'b0;
            err_tmo_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rd_pend_q   <= rd_pend_d;
            tmo_q       <= tmo_d;
            idx_q       <= idx_d;
            chk_q       <= chk_d;
            addr_sh_q   <= addr_sh_d;
            data_sh_q   <= data_sh_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_data_q  <= cmd_data_d;
            err_chk_q   <= err_chk_d;
            err_tmo_q   <= err_tmo_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign cmd_valid    = (state_q == S_OUT);
    assign cmd_addr     = cmd_addr_q;
    assign cmd_data     = cmd_data_q;
    assign err_checksum = err_chk_q;
    assign err_timeout  = err_tmo_q;
    assign frame_cnt    = frame_cnt_q;

endmodule
